// File: rtl/shift_sequencer.sv
// Multi-bit right-shift sequencer: one 1-bit shift per clock, result with a one-cycle done pulse.
// Optional macro SHIFT_SEQ_ARITH_EN adds an `arith` input selecting sign-fill (arithmetic) shifts.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] shift_amt,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic             arith,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             fill_q, fill_d;
    logic [AMT_W-1:0] amt_clamped;
    logic             start_fill;

    assign amt_clamped = (shift_amt >= AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : shift_amt;

`ifdef SHIFT_SEQ_ARITH_EN
    assign start_fill = arith & data_in[WIDTH-1];
`else
    assign start_fill = 1'b0;
`endif

    // data_out is loaded on the edge that enters DONE so it is valid while done is high.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d = data_in;
                    cnt_d  = amt_clamped;
                    fill_d = start_fill;
                    if (amt_clamped == '0) begin
                        state_d = DONE;
                        dout_d  = data_in;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = {fill_q, work_q[WIDTH-1:1]};
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                    dout_d  = work_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            fill_q  <= fill_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign data_out = dout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table plus scoreboard of expected results and done cycles.
module tb_shift_sequencer;
    localparam int W = 16;
    localparam int A = 5;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic [W-1:0] data_in;
    logic [A-1:0] shift_amt;
`ifdef SHIFT_SEQ_ARITH_EN
    logic         arith;
`else
    logic         ar_sink;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] data_out;

    shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .data_in   (data_in),
        .shift_amt (shift_amt),
`ifdef SHIFT_SEQ_ARITH_EN
        .arith     (arith),
`endif
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        int           amt;
        logic         ar;
        logic [W-1:0] exp;
    } vec_t;

    typedef struct {
        logic [W-1:0] exp;
        int           at;
    } sb_t;

    sb_t  sbq[$];
    sb_t  mon_e;
    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Every done pulse must match the oldest outstanding request, both value and cycle.
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: data_out=%h at cyc %0d", data_out, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_data", 32'(data_out), 32'(mon_e.exp));
                chk("done_cycle", cyc, mon_e.at);
            end
        end
    end

    // Called in the posedge+1 phase; waits for IDLE, drives start for one cycle.
    task automatic issue(input logic [W-1:0] d, input int amt, input logic ar,
                         input logic [W-1:0] exp, input bit push);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: busy=%b at cyc %0d", busy, cyc);
        end
        start     = 1'b1;
        data_in   = d;
        shift_amt = A'(amt);
`ifdef SHIFT_SEQ_ARITH_EN
        arith     = ar;
`else
        ar_sink   = ar;
`endif
        if (push) sbq.push_back('{exp, cyc + 1 + ((amt > W) ? W : amt)});
        @(posedge CLK); #1;
        start     = 1'b0;
        data_in   = W'($urandom);
        shift_amt = A'($urandom);
`ifdef SHIFT_SEQ_ARITH_EN
        arith     = ~ar;
`endif
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding at cyc %0d", sbq.size(), cyc);
            sbq.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt.push_back('{16'hABCD, 0,  1'b0, 16'hABCD});
        vt.push_back('{16'hFFFF, 20, 1'b0, 16'h0000});
        vt.push_back('{16'hF0F0, 4,  1'b0, 16'h0F0F});
        vt.push_back('{16'h1234, 16, 1'b0, 16'h0000});
        vt.push_back('{16'h8001, 15, 1'b0, 16'h0001});
        vt.push_back('{16'hFFFF, 1,  1'b0, 16'h7FFF});
        vt.push_back('{16'h5A5A, 31, 1'b0, 16'h0000});
        vt.push_back('{16'hC3A5, 2,  1'b0, 16'h30E9});
`ifdef SHIFT_SEQ_ARITH_EN
        vt.push_back('{16'h8000, 3,  1'b1, 16'hF000});
        vt.push_back('{16'h8000, 3,  1'b0, 16'h1000});
        vt.push_back('{16'h8000, 20, 1'b1, 16'hFFFF});
        vt.push_back('{16'h7FFF, 20, 1'b1, 16'h0000});
        vt.push_back('{16'hC001, 1,  1'b1, 16'hE000});
`endif

        RST       = 1'b1;
        start     = 1'b0;
        data_in   = '0;
        shift_amt = '0;
`ifdef SHIFT_SEQ_ARITH_EN
        arith     = 1'b0;
`else
        ar_sink   = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_data_out", 32'(data_out), 32'd0);
        RST = 1'b0;

        // Basic op: busy rises the cycle after start, drops the cycle after done.
        issue(16'hF0F0, 4, 1'b0, 16'h0F0F, 1'b1);
        chk("busy_after_start", 32'(busy), 32'd1);
        drain();
        chk("busy_after_done", 32'(busy), 32'd0);

        // Table: issued back to back, so throughput is checked through done_cycle.
        for (int i = 0; i < vt.size(); i++)
            issue(vt[i].d, vt[i].amt, vt[i].ar, vt[i].exp, 1'b1);
        drain();

        // A start pulse while busy must be dropped, not queued.
        issue(16'h8000, 8, 1'b0, 16'h0080, 1'b1);
        repeat (2) @(posedge CLK);
        #1;
        start     = 1'b1;
        data_in   = 16'h1234;
        shift_amt = 5'd1;
        @(posedge CLK); #1;
        start     = 1'b0;
        drain();
        repeat (5) @(posedge CLK);
        #1;
        chk("ignored_start_hold", 32'(data_out), 32'h0080);
        chk("ignored_start_idle", 32'(busy), 32'd0);

        // Reset mid-shift discards the op and clears data_out.
        issue(16'h8000, 10, 1'b0, 16'h0000, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_data_out", 32'(data_out), 32'd0);
        issue(16'h1234, 4, 1'b0, 16'h0123, 1'b1);
        drain();
        repeat (20) @(posedge CLK);
        #1;
        chk("final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
